// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one FP addsub unit among NREQ requesters,
// with a watchdog that aborts a hung operation and reports err.
module addsub_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      mode_in,
    input  logic [32*NREQ-1:0]   op1_in,
    input  logic [32*NREQ-1:0]   op2_in,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          result,
    output logic                 overflow,
    output logic                 err,
    output logic                 busy,
    output logic                 add_start,
    output logic                 mode,
    output logic [31:0]          op1,
    output logic [31:0]          op2,
    input  logic [31:0]          add_result,
    input  logic                 add_done,
    input  logic                 add_overflow
);
    localparam int LW = $clog2(NREQ);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [LW-1:0] last, sel, gidx;
    logic found;
    logic [7:0] cnt;
    logic timeout;
    assign timeout = cnt == 8'(TIMEOUT - 1);
    // first requester after the previous winner, wrapping modulo NREQ
    always_comb begin
        sel = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[LW'((int'(last) + k) % NREQ)]) begin
                sel = LW'((int'(last) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = (add_done || timeout) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            result    <= '0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            add_start <= 1'b0;
            mode      <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            last      <= LW'(NREQ - 1);
            gidx      <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            busy      <= state_n != IDLE;
            add_start <= state_n == ISSUE;
            done      <= '0;
            case (state)
                IDLE: if (found) begin
                    gidx  <= sel;
                    grant <= NREQ'(1) << sel;
                    mode  <= mode_in[sel];
                    op1   <= op1_in[32*int'(sel) +: 32];
                    op2   <= op2_in[32*int'(sel) +: 32];
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // a completion in the final watchdog cycle still counts as success
                    if (add_done) begin
                        result   <= add_result;
                        overflow <= add_overflow;
                        err      <= 1'b0;
                        done     <= NREQ'(1) << gidx;
                    end else if (timeout) begin
                        result   <= '0;
                        overflow <= 1'b0;
                        err      <= 1'b1;
                        done     <= NREQ'(1) << gidx;
                    end
                end
                default: begin
                    last  <= gidx;
                    grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: scenario tasks against a latency-programmable addsub model
// and a round-robin reference kept as plain integers.
module tb_addsub_arbiter;
    logic clk, rst;
    logic [3:0] req, mode_in, grant, done;
    logic [127:0] op1_in, op2_in;
    logic [31:0] result, op1, op2, add_result;
    logic overflow, err, busy, add_start, mode, add_done, add_overflow;
    int total = 0, bad = 0;
    int lat = 3, cd = -1, last_m = 3;
    bit model_on = 1;
    logic [31:0] ma, mb;

    addsub_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .mode_in(mode_in), .op1_in(op1_in), .op2_in(op2_in),
        .grant(grant), .done(done), .result(result), .overflow(overflow), .err(err), .busy(busy),
        .add_start(add_start), .mode(mode), .op1(op1), .op2(op2),
        .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40200000_40600000: return 32'h40C00000;
            64'h41200000_C0A00000: return 32'h40A00000;
            64'hC0A00000_C0400000: return 32'hC1000000;
            default:               return a + b;
        endcase
    endfunction

    function automatic logic ovf_model(input logic [31:0] a, input logic [31:0] b);
        return a[0] & b[0];
    endfunction

    initial forever begin
        @(negedge clk);
        if (add_start && model_on) begin
            cd = lat;
            ma = op1;
            mb = op2;
        end
    end

    initial begin
        add_done = 0; add_result = 0; add_overflow = 0;
        forever begin
            @(posedge clk); #1;
            add_done = 0;
            if (cd > 0) cd--;
            if (cd == 0) begin
                add_done = 1;
                add_result = fp_model(ma, mb);
                add_overflow = ovf_model(ma, mb);
                cd = -1;
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic set_lane(input int g, input logic [31:0] a, input logic [31:0] b);
        op1_in[32*g +: 32] = a;
        op2_in[32*g +: 32] = b;
    endtask

    task automatic do_reset;
        rst = 1; tick; tick; rst = 0;
        last_m = 3;
    endtask

    // called in an IDLE cycle with req already driven; returns in the following IDLE cycle
    task automatic serve(input int g, input logic [31:0] er, input logic eo, input logic ee, input int en);
        logic [31:0] x1, x2;
        logic xm;
        int n, starts;
        x1 = op1_in[32*g +: 32];
        x2 = op2_in[32*g +: 32];
        xm = mode_in[g];
        tick;
        total++;
        if (grant !== 4'(1 << g) || add_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL issue: grant=%b add_start=%b busy=%b, want grant=%b add_start=1 busy=1", grant, add_start, busy, 4'(1 << g));
        end
        total++;
        if (op1 !== x1 || op2 !== x2 || mode !== xm) begin
            bad++;
            $display("FAIL operands: op1=%h op2=%h mode=%b, want %h %h %b", op1, op2, mode, x1, x2, xm);
        end
        set_lane(g, $urandom, $urandom);
        n = 0;
        starts = 0;
        while (done === 4'b0 && n < 40) begin
            tick;
            n++;
            if (add_start) starts++;
        end
        total++;
        if (done !== 4'(1 << g)) begin
            bad++;
            $display("FAIL done: got %b, want %b", done, 4'(1 << g));
        end
        total++;
        if (n != en) begin
            bad++;
            $display("FAIL latency: got %0d cycles after add_start, want %0d", n, en);
        end
        total++;
        if (result !== er || overflow !== eo || err !== ee) begin
            bad++;
            $display("FAIL response: result=%h ovf=%b err=%b, want %h %b %b", result, overflow, err, er, eo, ee);
        end
        total++;
        if (starts != 0) begin
            bad++;
            $display("FAIL extra_start: got %0d extra add_start pulses, want 0", starts);
        end
        req[g] = 0;
        last_m = g;
        tick;
        total++;
        if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL release: grant=%b done=%b busy=%b, want 0 0 0", grant, done, busy);
        end
    endtask

    task automatic test_reset;
        req = 4'b1111;
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            tick;
            total++;
            if ({grant, done, result, overflow, err, busy, add_start, mode, op1, op2} !== '0) begin
                bad++;
                $display("FAIL reset_outputs: grant=%b done=%b result=%h busy=%b add_start=%b op1=%h op2=%h, want all 0",
                         grant, done, result, busy, add_start, op1, op2);
            end
        end
        rst = 0;
        last_m = 3;
        lat = 2;
        serve(0, fp_model(op1_in[31:0], op2_in[31:0]), ovf_model(op1_in[31:0], op2_in[31:0]), 0, 3);
        req = 0;
    endtask

    task automatic test_single;
        lat = 3;
        set_lane(0, 32'h40200000, 32'h40600000);
        mode_in = 0;
        req = 4'b0001;
        serve(0, 32'h40C00000, 0, 0, 4);
    endtask

    task automatic test_contention;
        do_reset;
        lat = 2;
        for (int r = 0; r < 2; r++) begin
            set_lane(0, 32'h41200000, 32'hC0A00000);
            set_lane(1, 32'hC0A00000, 32'hC0400000);
            req = 4'b0011;
            serve(0, 32'h40A00000, 0, 0, 3);
            serve(1, 32'hC1000000, 0, 0, 3);
        end
    endtask

    task automatic test_fairness;
        int g;
        do_reset;
        for (int i = 0; i < 4; i++) set_lane(i, $urandom, $urandom);
        mode_in = 4'($urandom);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            g = k % 4;
            lat = $urandom_range(1, 6);
            serve(g, fp_model(op1_in[32*g +: 32], op2_in[32*g +: 32]),
                  ovf_model(op1_in[32*g +: 32], op2_in[32*g +: 32]), 0, lat + 1);
            req[g] = 1;
        end
        req = 0;
        tick;
        tick;
    endtask

    task automatic test_timeout;
        int quiet;
        model_on = 0;
        req = 4'b0100;
        serve(2, 32'h0, 0, 1, 17);
        cd = 1;
        quiet = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (done !== 4'b0 || busy !== 1'b0 || grant !== 4'b0) quiet++;
        end
        total++;
        if (quiet != 0) begin
            bad++;
            $display("FAIL late_done: %0d cycles reacted to a stray add_done, want 0", quiet);
        end
        model_on = 1;
        lat = 16;
        req = 4'b0100;
        serve(2, fp_model(op1_in[95:64], op2_in[95:64]), ovf_model(op1_in[95:64], op2_in[95:64]), 0, 17);
        lat = 4;
        req = 4'b0100;
        serve(2, fp_model(op1_in[95:64], op2_in[95:64]), ovf_model(op1_in[95:64], op2_in[95:64]), 0, 5);
    endtask

    task automatic test_reset_wait;
        int stray;
        lat = 5;
        req = 4'b0010;
        tick;
        total++;
        if (grant !== 4'b0010 || add_start !== 1'b1) begin
            bad++;
            $display("FAIL rw_grant: grant=%b add_start=%b, want 0010 1", grant, add_start);
        end
        tick;
        tick;
        rst = 1;
        tick;
        req = 0;
        total++;
        if (grant !== 4'b0 || busy !== 1'b0 || add_start !== 1'b0 || op1 !== 32'h0) begin
            bad++;
            $display("FAIL rw_reset: grant=%b busy=%b add_start=%b op1=%h, want 0", grant, busy, add_start, op1);
        end
        tick;
        rst = 0;
        last_m = 3;
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (done !== 4'b0 || busy !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL rw_stray: %0d cycles with done/busy after reset, want 0", stray);
        end
        lat = 3;
        req = 4'b0011;
        serve(0, fp_model(op1_in[31:0], op2_in[31:0]), ovf_model(op1_in[31:0], op2_in[31:0]), 0, 4);
        serve(1, fp_model(op1_in[63:32], op2_in[63:32]), ovf_model(op1_in[63:32], op2_in[63:32]), 0, 4);
    endtask

    initial begin
        rst = 1;
        req = 0;
        mode_in = 0;
        op1_in = {$urandom, $urandom, $urandom, $urandom};
        op2_in = {$urandom, $urandom, $urandom, $urandom};
        tick;
        test_reset;
        test_single;
        test_contention;
        test_fairness;
        test_timeout;
        test_reset_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
